// File: rtl/branch_compare_unit_pkg.sv
// Shared types and constants for the branch compare unit.
// The optional taken-branch statistics counter is enabled by BRANCH_CMP_STATS_EN.
package branch_cmp_pkg;

   typedef enum logic [2:0] {
      BEQ  = 3'b000,
      BNE  = 3'b001,
      BLT  = 3'b100,
      BGE  = 3'b101,
      BLTU = 3'b110,
      BGEU = 3'b111
   } branch_funct3_t;

   localparam int STATS_W = 16;

endpackage

// File: rtl/branch_compare_unit_if.sv
// Operand/result handshake bundle between forwarding stage, compare unit and PC select.
// taken_count exists only when BRANCH_CMP_STATS_EN is defined.
interface branch_cmp_if
   import branch_cmp_pkg::*;
#(
   parameter int N = 32
);
   logic                in_valid;
   logic                in_ready;
   logic [N-1:0]        a;
   logic [N-1:0]        b;
   logic [2:0]          funct3;
   logic                out_valid;
   logic                out_ready;
   logic                taken;
   logic                illegal;
`ifdef BRANCH_CMP_STATS_EN
   logic [STATS_W-1:0]  taken_count;
`endif

   modport master (
      output in_valid, a, b, funct3, out_ready,
      input  in_ready, out_valid, taken, illegal
`ifdef BRANCH_CMP_STATS_EN
      , input taken_count
`endif
   );

   modport slave (
      input  in_valid, a, b, funct3, out_ready,
      output in_ready, out_valid, taken, illegal
`ifdef BRANCH_CMP_STATS_EN
      , output taken_count
`endif
   );

endinterface

// File: rtl/branch_compare_unit_cond_eval.sv
// Combinational branch condition: comparator results selected by the RISC-V funct3.
module branch_cond_eval
   import branch_cmp_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [2:0]   funct3,
   output logic         taken_next,
   output logic         illegal_next
);
   logic eq;
   logic lt;
   logic ltu;

   comparator_eq          #(.N(N)) u_eq  (.a(a), .b(b), .eq(eq));
   comparator_lt          #(.N(N)) u_lt  (.a(a), .b(b), .lt(lt));
   comparator_lt_unsigned #(.N(N)) u_ltu (.a(a), .b(b), .ltu(ltu));

   // Codes 010/011 are not branches; they resolve not-taken and are flagged.
   always_comb begin
      taken_next   = 1'b0;
      illegal_next = 1'b0;
      case (branch_funct3_t'(funct3))
         BEQ:     taken_next = eq;
         BNE:     taken_next = !eq;
         BLT:     taken_next = lt;
         BGE:     taken_next = !lt;
         BLTU:    taken_next = ltu;
         BGEU:    taken_next = !ltu;
         default: illegal_next = 1'b1;
      endcase
   end
endmodule

// File: rtl/comparators.sv
// Basic operand comparators consumed by the branch condition evaluator.
module comparator_eq #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         eq
);
   assign eq = (a == b);
endmodule

module comparator_lt #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         lt
);
   assign lt = ($signed(a) < $signed(b));
endmodule

module comparator_lt_unsigned #(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         ltu
);
   assign ltu = (a < b);
endmodule

// File: rtl/branch_compare_unit.sv
// Two-stage pipelined branch-condition evaluator with valid/ready handshake.
// Define BRANCH_CMP_STATS_EN to add the saturating taken_count statistics counter.
module branch_compare_unit
   import branch_cmp_pkg::*;
#(
   parameter int N = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   branch_cmp_if.slave bus
);
   logic [N-1:0] s1_a;
   logic [N-1:0] s1_b;
   logic [2:0]   s1_funct3;
   logic         s1_valid;
   logic         s2_valid;
   logic         s2_taken;
   logic         s2_illegal;
   logic         s2_advance;
   logic         s1_advance;
   logic         accept;
   logic         taken_next;
   logic         illegal_next;

   assign s2_advance   = !s2_valid || bus.out_ready;
   assign s1_advance   = !s1_valid || s2_advance;
   assign bus.in_ready = s1_advance && !flush;
   assign accept       = bus.in_valid && bus.in_ready;

   branch_cond_eval #(.N(N)) u_eval (
      .a            (s1_a),
      .b            (s1_b),
      .funct3       (s1_funct3),
      .taken_next   (taken_next),
      .illegal_next (illegal_next)
   );

   // Operand registers carry no reset; their contents only matter while s1_valid.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_a      <= bus.a;
         s1_b      <= bus.b;
         s1_funct3 <= bus.funct3;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s2_valid   <= 1'b0;
         s2_taken   <= 1'b0;
         s2_illegal <= 1'b0;
      end else if (flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (s2_advance) begin
            s2_valid   <= s1_valid;
            s2_taken   <= s1_valid && taken_next;
            s2_illegal <= s1_valid && illegal_next;
         end
         if (s1_advance) begin
            s1_valid <= bus.in_valid;
         end
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.taken     = s2_taken;
   assign bus.illegal   = s2_illegal;

`ifdef BRANCH_CMP_STATS_EN
   logic [STATS_W-1:0] taken_count;

   // Counts delivered taken results, including one delivered during a flush cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         taken_count <= '0;
      end else if (s2_valid && bus.out_ready && s2_taken && (taken_count != {STATS_W{1'b1}})) begin
         taken_count <= taken_count + 1'b1;
      end
   end

   assign bus.taken_count = taken_count;
`endif

endmodule

// File: tb/tb_branch_compare_unit.sv
// Directed self-checking bench for branch_compare_unit; inputs driven and outputs sampled on negedge.
module tb_branch_compare_unit;
   import branch_cmp_pkg::*;

   logic clk;
   logic rst;
   logic flush;
   int   total;
   int   bad;

   branch_cmp_if #(.N(32)) bus ();

   branch_compare_unit #(.N(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset;
      rst           = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.a         = '0;
      bus.b         = '0;
      bus.funct3    = 3'b000;
      repeat (2) @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0 || bus.taken !== 1'b0 || bus.illegal !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_outputs: got valid=%b taken=%b illegal=%b, want 0 0 0", bus.out_valid, bus.taken, bus.illegal);
      end
`ifdef BRANCH_CMP_STATS_EN
      total++;
      if (bus.taken_count !== 16'd0) begin
         bad++;
         $display("[TB] FAIL reset_count: got %0d want 0", bus.taken_count);
      end
`endif
      rst = 1'b0;
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_single_beq;
      bus.a = 32'd5; bus.b = 32'd5; bus.funct3 = BEQ; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL single_early: out_valid got %b want 0 one edge after accept", bus.out_valid);
      end
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.taken !== 1'b1 || bus.illegal !== 1'b0) begin
         bad++;
         $display("[TB] FAIL single_beq: got valid=%b taken=%b illegal=%b, want 1 1 0", bus.out_valid, bus.taken, bus.illegal);
      end
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL single_drain: out_valid got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_boundary;
      logic [2:0] fs [3] = '{BLT, BLTU, BGEU};
      logic       ex [3] = '{1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         bus.a = 32'h8000_0000; bus.b = 32'h7FFF_FFFF; bus.funct3 = fs[i]; bus.in_valid = 1'b1;
         @(negedge clk);
         bus.in_valid = 1'b0;
         @(negedge clk);
         total++;
         if (bus.out_valid !== 1'b1 || bus.taken !== ex[i] || bus.illegal !== 1'b0) begin
            bad++;
            $display("[TB] FAIL boundary_%0d: got valid=%b taken=%b illegal=%b, want 1 %b 0", i, bus.out_valid, bus.taken, bus.illegal, ex[i]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_illegal;
      logic [2:0] fs [2] = '{3'b010, 3'b011};
      for (int i = 0; i < 2; i++) begin
         bus.a = 32'd1; bus.b = 32'd1; bus.funct3 = fs[i]; bus.in_valid = 1'b1;
         @(negedge clk);
         bus.in_valid = 1'b0;
         @(negedge clk);
         total++;
         if (bus.out_valid !== 1'b1 || bus.taken !== 1'b0 || bus.illegal !== 1'b1) begin
            bad++;
            $display("[TB] FAIL illegal_%0d: got valid=%b taken=%b illegal=%b, want 1 0 1", i, bus.out_valid, bus.taken, bus.illegal);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [31:0] ta [8] = '{32'hFFFF_FFFF, 32'd0, 32'd3, 32'd7, 32'd10, 32'hFFFF_FFFB, 32'd1, 32'd2};
      logic [31:0] tb [8] = '{32'd1, 32'd0, 32'd7, 32'd3, 32'd10, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'd3};
      logic [2:0]  tf [8] = '{BLT, BNE, BLTU, BGEU, BEQ, BGE, BLTU, BGE};
      logic        te [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      bus.out_ready = 1'b1;
      for (int j = 0; j <= 10; j++) begin
         if (j >= 2 && j < 10) begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.taken !== te[j-2]) begin
               bad++;
               $display("[TB] FAIL stream_%0d: got valid=%b taken=%b, want 1 %b", j-2, bus.out_valid, bus.taken, te[j-2]);
            end
         end else if (j == 10) begin
            total++;
            if (bus.out_valid !== 1'b0) begin
               bad++;
               $display("[TB] FAIL stream_end: out_valid got %b want 0", bus.out_valid);
            end
         end
         if (j < 8) begin
            total++;
            if (bus.in_ready !== 1'b1) begin
               bad++;
               $display("[TB] FAIL stream_ready_%0d: in_ready got %b want 1", j, bus.in_ready);
            end
            bus.a = ta[j]; bus.b = tb[j]; bus.funct3 = tf[j]; bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         if (j < 10) @(negedge clk);
      end
   endtask

   task automatic test_backpressure;
      bus.out_ready = 1'b0;
      bus.a = 32'd1; bus.b = 32'd2; bus.funct3 = BLT; bus.in_valid = 1'b1;
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL bp_second_accept: got in_ready=%b valid=%b, want 1 0", bus.in_ready, bus.out_valid);
      end
      bus.a = 32'd2; bus.b = 32'd1; bus.funct3 = 3'b010;
      @(negedge clk);
      bus.a = 32'd9; bus.b = 32'd9; bus.funct3 = BGEU;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (bus.out_valid !== 1'b1 || bus.taken !== 1'b1 || bus.illegal !== 1'b0 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_hold_%0d: got valid=%b taken=%b illegal=%b in_ready=%b, want 1 1 0 0", k, bus.out_valid, bus.taken, bus.illegal, bus.in_ready);
         end
         if (k < 2) @(negedge clk);
      end
      bus.out_ready = 1'b1;
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL bp_release_ready: in_ready got %b want 1", bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      total++;
      if (bus.out_valid !== 1'b1 || bus.taken !== 1'b0 || bus.illegal !== 1'b1) begin
         bad++;
         $display("[TB] FAIL bp_result1: got valid=%b taken=%b illegal=%b, want 1 0 1", bus.out_valid, bus.taken, bus.illegal);
      end
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.taken !== 1'b1 || bus.illegal !== 1'b0) begin
         bad++;
         $display("[TB] FAIL bp_result2: got valid=%b taken=%b illegal=%b, want 1 1 0", bus.out_valid, bus.taken, bus.illegal);
      end
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL bp_no_dup: out_valid got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_flush;
      bus.out_ready = 1'b0;
      bus.a = 32'd4; bus.b = 32'd4; bus.funct3 = BEQ; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.funct3 = BNE;
      @(negedge clk);
      bus.in_valid = 1'b1;
      flush = 1'b1;
      #1;
      total++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL flush_cycle: got in_ready=%b valid=%b, want 0 1", bus.in_ready, bus.out_valid);
      end
      @(negedge clk);
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL flush_s2: out_valid got %b want 0", bus.out_valid);
      end
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL flush_s1: out_valid got %b want 0", bus.out_valid);
      end
   endtask

`ifdef BRANCH_CMP_STATS_EN
   task automatic test_stats;
      logic [2:0] sf [5] = '{BEQ, BNE, BEQ, BNE, BEQ};
      rst = 1'b1;
      #2;
      rst = 1'b0;
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.a = 32'd6; bus.b = 32'd6;
      for (int i = 0; i < 5; i++) begin
         bus.funct3 = sf[i]; bus.in_valid = 1'b1;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (bus.taken_count !== 16'd3) begin
         bad++;
         $display("[TB] FAIL stats_count: got %0d want 3", bus.taken_count);
      end
   endtask
`endif

   task automatic test_reset_mid;
      bus.out_ready = 1'b0;
      bus.a = 32'd0; bus.b = 32'd1; bus.funct3 = BLTU; bus.in_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      total++;
      if (bus.out_valid !== 1'b1 || bus.taken !== 1'b1) begin
         bad++;
         $display("[TB] FAIL rstmid_pre: got valid=%b taken=%b, want 1 1", bus.out_valid, bus.taken);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (bus.out_valid !== 1'b0 || bus.taken !== 1'b0 || bus.illegal !== 1'b0) begin
         bad++;
         $display("[TB] FAIL rstmid_async: got valid=%b taken=%b illegal=%b, want 0 0 0", bus.out_valid, bus.taken, bus.illegal);
      end
`ifdef BRANCH_CMP_STATS_EN
      total++;
      if (bus.taken_count !== 16'd0) begin
         bad++;
         $display("[TB] FAIL rstmid_count: got %0d want 0", bus.taken_count);
      end
`endif
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      bus.a = 32'd3; bus.b = 32'd3; bus.funct3 = BGE; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.taken !== 1'b1) begin
         bad++;
         $display("[TB] FAIL rstmid_first_accept: got valid=%b taken=%b, want 1 1", bus.out_valid, bus.taken);
      end
      @(negedge clk);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_single_beq();
      test_boundary();
      test_illegal();
      test_back_to_back();
      test_backpressure();
      test_flush();
`ifdef BRANCH_CMP_STATS_EN
      test_stats();
`endif
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
